// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared encodings for the iterative multiply/divide unit.
//   mdu_op_e    - MduOp encodings (MULT, MULTU, DIV, DIVU)
//   mdu_state_e - controller states (IDLE -> RUN -> FIX -> IDLE)
package mdu_ctrl_pkg;

    localparam int unsigned SIZE_MDUOP = 2;

    typedef enum logic [SIZE_MDUOP-1:0] {
        MDUOP_MULT  = 2'b00,
        MDUOP_MULTU = 2'b01,
        MDUOP_DIV   = 2'b10,
        MDUOP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'b00,
        MDU_ST_RUN  = 2'b01,
        MDU_ST_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDUOP_MULT) || (op == MDUOP_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl_step.sv
// mdu_step: one combinational iteration of the shared datapath.
//   div_i  in  1        0: shift-add multiply step, 1: restoring divide step
//   acc_i  in  2*WIDTH  multiply: {partial hi, multiplier/low product}
//                       divide:   {remainder, dividend/quotient}
//   opnd_i in  WIDTH    multiplicand magnitude / divisor magnitude
//   acc_o  out 2*WIDTH  accumulator after this iteration; in divide mode the
//                       new quotient bit is shifted into bit 0
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole WIDTH+1+WIDTH-1 right.
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: shift the next dividend bit into the remainder, trial subtract.
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        // A set top bit of the shifted remainder already exceeds any divisor.
        ge      = shifted[WIDTH] | ~diff[WIDTH];
        if (div_i) begin
            acc_o = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU controller owning HI/LO.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   Start, MduOp      mul/div instruction in EX and its operation code
//   SrcA, SrcB        multiplicand/dividend, multiplier/divisor
//   WriteHi/WriteLo   MTHI/MTLO with data WrData
//   HiLoRead          MFHI/MFLO in EX
//   Flush             squash the in-flight operation
//   Hi, Lo            architectural HI/LO registers
//   Busy              operation in flight (registered)
//   Done              one-cycle pulse after HI/LO update
//   StallReq          hold EX while the unit is busy and EX needs it
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [SIZE_MDUOP-1:0] MduOp,
    input  logic [WIDTH-1:0]      SrcA,
    input  logic [WIDTH-1:0]      SrcB,
    input  logic                  WriteHi,
    input  logic                  WriteLo,
    input  logic [WIDTH-1:0]      WrData,
    input  logic                  HiLoRead,
    input  logic                  Flush,
    output logic [WIDTH-1:0]      Hi,
    output logic [WIDTH-1:0]      Lo,
    output logic                  Busy,
    output logic                  Done,
    output logic                  StallReq
);

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;     // product / quotient sign
    logic                 rneg_q, rneg_d;   // remainder sign
    logic                 dz_q, dz_d;       // divide by zero
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    mdu_op_e              op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (is_div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    assign op    = mdu_op_e'(MduOp);
    assign a_neg = op_is_signed(op) & SrcA[WIDTH-1];
    assign b_neg = op_is_signed(op) & SrcB[WIDTH-1];
    assign abs_a = a_neg ? -SrcA : SrcA;
    assign abs_b = b_neg ? -SrcB : SrcB;

    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        raw_a_d  = raw_a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            MDU_ST_IDLE: begin
                if (Start && !Flush) begin
                    state_d  = MDU_ST_RUN;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    is_div_d = op_is_div(op);
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dz_d     = op_is_div(op) && (SrcB == '0);
                    raw_a_d  = SrcA;
                    if (op_is_div(op)) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end else begin
                    if (WriteHi) hi_d = WrData;
                    if (WriteLo) lo_d = WrData;
                end
            end
            MDU_ST_RUN: begin
                if (Flush) begin
                    state_d = MDU_ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == '0) begin
                        state_d = MDU_ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            MDU_ST_FIX: begin
                state_d = MDU_ST_IDLE;
                if (!Flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = raw_a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = MDU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            raw_a_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            raw_a_q  <= raw_a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Hi       = hi_q;
    assign Lo       = lo_q;
    assign Busy     = (state_q != MDU_ST_IDLE);
    assign Done     = done_q;
    assign StallReq = Busy & (Start | WriteHi | WriteLo | HiLoRead);

endmodule
